// File: rtl/reg_list_encoder_if.sv
// Bus between instruction decode and the LDM/STM register-list sequencer.
// The master drives start/reg_list/advance; the slave returns the current
// transfer (register number, index, totals) and its status flags.
interface reg_list_encoder_if #(
   parameter int LIST_W = 16,
   parameter int IDX_W  = 4
);
   logic              start;
   logic [LIST_W-1:0] reg_list;
   logic              advance;
   logic [IDX_W-1:0]  reg_num;
   logic              valid;
   logic              last;
   logic [IDX_W:0]    xfer_idx;
   logic [IDX_W:0]    total;
   logic              busy;
   logic              done;

   modport master (
      output start, reg_list, advance,
      input  reg_num, valid, last, xfer_idx, total, busy, done
   );

   modport slave (
      input  start, reg_list, advance,
      output reg_num, valid, last, xfer_idx, total, busy, done
   );
endinterface

// File: rtl/reg_list_encoder.sv
// LDM/STM register-list sequencer: latches a register list and emits its set
// bits lowest-first as register numbers, one per consumed transfer. All
// outputs are decoded from registered state only, so there is no
// input-to-output combinational path.
module reg_list_encoder #(
   parameter int LIST_W = 16,
   parameter int IDX_W  = 4
) (
   input  logic               clk,
   input  logic               reset,
   reg_list_encoder_if.slave  bus
);

   typedef enum logic [1:0] {
      IDLE_S   = 2'd0,
      ACTIVE_S = 2'd1,
      DONE_S   = 2'd2
   } state_t;

   // Number of set bits; the result needs IDX_W+1 bits to hold LIST_W itself.
   function automatic logic [IDX_W:0] popcount(input logic [LIST_W-1:0] v);
      logic [IDX_W:0] cnt;
      cnt = '0;
      for (int i = 0; i < LIST_W; i++) begin
         cnt = cnt + {{IDX_W{1'b0}}, v[i]};
      end
      return cnt;
   endfunction

   // Index of the lowest set bit; zero when nothing is set.
   function automatic logic [IDX_W-1:0] lowest_set_idx(input logic [LIST_W-1:0] v);
      logic [IDX_W-1:0] idx;
      idx = '0;
      for (int i = LIST_W - 1; i >= 0; i--) begin
         if (v[i]) begin
            idx = IDX_W'(i);
         end else begin
            idx = idx;
         end
      end
      return idx;
   endfunction

   state_t            state_q,    state_d;
   logic [LIST_W-1:0] pending_q,  pending_d;
   logic [IDX_W:0]    xfer_idx_q, xfer_idx_d;
   logic [IDX_W:0]    total_q,    total_d;

   logic [IDX_W-1:0]  reg_num_s;
   logic              valid_s;
   logic              last_s;
   logic              busy_s;
   logic              done_s;

   // State register and list datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE_S;
         pending_q  <= '0;
         xfer_idx_q <= '0;
         total_q    <= '0;
      end else begin
         state_q    <= state_d;
         pending_q  <= pending_d;
         xfer_idx_q <= xfer_idx_d;
         total_q    <= total_d;
      end
   end

   // Next-state logic: accept a list in IDLE, retire the lowest bit on advance.
   always_comb begin
      state_d    = state_q;
      pending_d  = pending_q;
      xfer_idx_d = xfer_idx_q;
      total_d    = total_q;
      case (state_q)
         IDLE_S: begin
            if (bus.start) begin
               pending_d  = bus.reg_list;
               total_d    = popcount(bus.reg_list);
               xfer_idx_d = '0;
               // An empty list has no transfers and goes straight to DONE.
               if (bus.reg_list != '0) begin
                  state_d = ACTIVE_S;
               end else begin
                  state_d = DONE_S;
               end
            end else begin
               state_d = IDLE_S;
            end
         end
         ACTIVE_S: begin
            if (bus.advance) begin
               // v & (v - 1) clears exactly the lowest set bit.
               pending_d  = pending_q & (pending_q - LIST_W'(1));
               xfer_idx_d = xfer_idx_q + (IDX_W + 1)'(1);
               if (last_s) begin
                  state_d = DONE_S;
               end else begin
                  state_d = ACTIVE_S;
               end
            end else begin
               state_d = ACTIVE_S;
            end
         end
         DONE_S: begin
            state_d = IDLE_S;
         end
         default: begin
            state_d   = IDLE_S;
            pending_d = '0;
         end
      endcase
   end

   // Output decode from registered state only.
   always_comb begin
      reg_num_s = '0;
      valid_s   = 1'b0;
      last_s    = 1'b0;
      busy_s    = 1'b0;
      done_s    = 1'b0;
      case (state_q)
         IDLE_S: begin
            busy_s = 1'b0;
         end
         ACTIVE_S: begin
            valid_s   = 1'b1;
            busy_s    = 1'b1;
            reg_num_s = lowest_set_idx(pending_q);
            // Exactly one bit pending: nonzero and a power of two.
            last_s    = (pending_q != '0) &&
                        ((pending_q & (pending_q - LIST_W'(1))) == '0);
         end
         DONE_S: begin
            busy_s = 1'b1;
            done_s = 1'b1;
         end
         default: begin
            busy_s = 1'b0;
         end
      endcase
   end

   assign bus.reg_num  = reg_num_s;
   assign bus.valid    = valid_s;
   assign bus.last     = last_s;
   assign bus.busy     = busy_s;
   assign bus.done     = done_s;
   assign bus.xfer_idx = xfer_idx_q;
   assign bus.total    = total_q;

endmodule

// File: tb/tb_reg_list_encoder.sv
// Self-checking bench for reg_list_encoder. The reference model expands each
// list into a queue of expected register numbers and pops one per advance.
module tb_reg_list_encoder;

   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   reg_list_encoder_if bus ();

   reg_list_encoder dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic chk_quiet(input string tag, input logic [31:0] xf, input logic [31:0] tot);
      chk_eq({tag, ".busy"},  32'(bus.busy),  32'd0);
      chk_eq({tag, ".valid"}, 32'(bus.valid), 32'd0);
      chk_eq({tag, ".done"},  32'(bus.done),  32'd0);
      chk_eq({tag, ".last"},  32'(bus.last),  32'd0);
      chk_eq({tag, ".xfer"},  32'(bus.xfer_idx), xf);
      chk_eq({tag, ".total"}, 32'(bus.total), tot);
   endtask

   // Run one list. Advance is either random (percentage) or taken LSB-first
   // from pattern bits. poke makes the bench fire stray starts while busy.
   task automatic run_list(input logic [15:0] lst, input int adv_pct,
                           input bit use_pat, input logic [31:0] pat,
                           input bit poke, input string tag);
      int q[$];
      int n;
      int xf;
      int cycles;
      int step;
      bit adv;
      logic [15:0] acc;
      q.delete();
      for (int i = 0; i < 16; i++) begin
         if (lst[i]) q.push_back(i);
      end
      n = q.size();
      xf = 0;
      cycles = 0;
      step = 0;
      acc = 16'h0000;

      @(negedge clk);
      bus.start    = 1'b1;
      bus.reg_list = lst;
      bus.advance  = 1'b1;             // advance outside ACTIVE must be ignored
      @(negedge clk);
      bus.start    = 1'b0;
      bus.advance  = 1'b0;

      while (q.size() != 0 && cycles < 400) begin
         chk_eq({tag, ".valid"},   32'(bus.valid), 32'd1);
         chk_eq({tag, ".reg_num"}, 32'(bus.reg_num), 32'(q[0]));
         chk_eq({tag, ".last"},    32'(bus.last), 32'(q.size() == 1));
         chk_eq({tag, ".xfer"},    32'(bus.xfer_idx), 32'(xf));
         chk_eq({tag, ".total"},   32'(bus.total), 32'(n));
         chk_eq({tag, ".busy"},    32'(bus.busy), 32'd1);
         chk_eq({tag, ".done"},    32'(bus.done), 32'd0);
         if (use_pat) adv = pat[step];
         else         adv = ($urandom_range(0, 99) < adv_pct);
         bus.advance = adv;
         if (poke) begin
            bus.start    = 1'b1;
            bus.reg_list = 16'($urandom);
         end
         @(negedge clk);
         bus.start   = 1'b0;
         bus.advance = 1'b0;
         if (adv) begin
            acc = acc | (16'h0001 << q[0]);   // decoder_4x16 with enable=1
            void'(q.pop_front());
            xf++;
         end
         cycles++;
         step++;
      end
      if (q.size() != 0) chk_eq({tag, ".timeout"}, 32'(q.size()), 32'd0);
      if (adv_pct == 100 && !use_pat) chk_eq({tag, ".latency"}, 32'(cycles), 32'(n));

      // DONE cycle: one-cycle pulse, stray start/advance still ignored.
      chk_eq({tag, ".done_pulse"}, 32'(bus.done), 32'd1);
      chk_eq({tag, ".done_busy"},  32'(bus.busy), 32'd1);
      chk_eq({tag, ".done_valid"}, 32'(bus.valid), 32'd0);
      chk_eq({tag, ".done_xfer"},  32'(bus.xfer_idx), 32'(n));
      chk_eq({tag, ".done_total"}, 32'(bus.total), 32'(n));
      if (poke) begin
         bus.start    = 1'b1;
         bus.reg_list = 16'hA5A5;
      end
      bus.advance = 1'b1;
      @(negedge clk);
      bus.start   = 1'b0;
      bus.advance = 1'b1;
      chk_quiet({tag, ".idle"}, 32'(n), 32'(n));
      @(negedge clk);
      bus.advance = 1'b0;
      chk_quiet({tag, ".hold"}, 32'(n), 32'(n));
      chk_eq({tag, ".decode_or"}, 32'(acc), 32'(lst));
   endtask

   initial begin
      logic [15:0] rl;
      reset        = 1'b1;
      bus.start    = 1'b0;
      bus.reg_list = 16'h0000;
      bus.advance  = 1'b0;
      repeat (3) @(negedge clk);
      chk_quiet("reset", 32'd0, 32'd0);
      chk_eq("reset.reg_num", 32'(bus.reg_num), 32'd0);
      reset = 1'b0;

      // Reset in the middle of a list.
      @(negedge clk);
      bus.start    = 1'b1;
      bus.reg_list = 16'h00F0;
      @(negedge clk);
      bus.start    = 1'b0;
      chk_eq("midrst.reg_num0", 32'(bus.reg_num), 32'd4);
      bus.advance  = 1'b1;
      @(negedge clk);
      bus.advance  = 1'b0;
      chk_eq("midrst.reg_num1", 32'(bus.reg_num), 32'd5);
      chk_eq("midrst.xfer1",    32'(bus.xfer_idx), 32'd1);
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      chk_quiet("midrst.after", 32'd0, 32'd0);
      chk_eq("midrst.reg_num", 32'(bus.reg_num), 32'd0);
      @(negedge clk);
      chk_quiet("midrst.stay", 32'd0, 32'd0);

      run_list(16'h8421, 100, 1'b0, 32'd0, 1'b0, "spread");
      run_list(16'h0006, 0, 1'b1, 32'b10010, 1'b0, "stall");
      run_list(16'h0000, 100, 1'b0, 32'd0, 1'b0, "empty");
      run_list(16'hFFFF, 100, 1'b0, 32'd0, 1'b1, "full");
      run_list(16'h8000, 100, 1'b0, 32'd0, 1'b0, "r15");
      run_list(16'h0001, 50, 1'b0, 32'd0, 1'b1, "r0");

      for (int k = 0; k < 20; k++) begin
         rl = 16'($urandom);
         if (k % 4 == 1) rl = rl & 16'($urandom);
         run_list(rl, int'($urandom_range(30, 100)), 1'b0, 32'd0, bit'(k % 2), "rand");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
